// File: rtl/instruction_predecode_buffer.sv
// Instruction FIFO between fetch and field extraction. Each opcode is classified
// into group/specifier/illegal as it is written, so the head entry drives the extractor directly.
module instruction_predecode_buffer #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [31:0]              in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [24:0]              out_instruction_data,
    output logic [6:0]               out_opcode,
    output logic [1:0]               out_group,
    output logic                     out_specifier,
    output logic                     out_illegal,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic [24:0]   r_data [DEPTH];
    logic [6:0]    r_op   [DEPTH];
    logic [1:0]    r_grp  [DEPTH];
    logic          r_spec [DEPTH];
    logic          r_ill  [DEPTH];
    logic [31:0]   r_pc   [DEPTH];

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [1:0]    w_grp;
    logic          w_spec;
    logic          w_ill;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    // in_ready looks only at occupancy, so a pop never opens a slot in the same cycle
    assign w_push  = in_valid && !w_full && !flush;
    assign w_pop   = !w_empty && out_ready && !flush;

    always_comb begin
        w_grp  = 2'b00;
        w_spec = 1'b0;
        w_ill  = 1'b0;
        case (in_instr[6:0])
            7'b0110011:                       begin w_grp = 2'b01; w_spec = 1'b0; end
            7'b0010011, 7'b0000011, 7'b1100111: begin w_grp = 2'b01; w_spec = 1'b1; end
            7'b0100011:                       begin w_grp = 2'b10; w_spec = 1'b0; end
            7'b1100011:                       begin w_grp = 2'b10; w_spec = 1'b1; end
            7'b0110111, 7'b0010111:           begin w_grp = 2'b11; w_spec = 1'b0; end
            7'b1101111:                       begin w_grp = 2'b11; w_spec = 1'b1; end
            default:                          w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_op[i]   <= '0;
                r_grp[i]  <= '0;
                r_spec[i] <= 1'b0;
                r_ill[i]  <= 1'b0;
                r_pc[i]   <= '0;
            end
        end else if (w_push) begin
            r_data[r_wr_ptr] <= in_instr[31:7];
            r_op[r_wr_ptr]   <= in_instr[6:0];
            r_grp[r_wr_ptr]  <= w_grp;
            r_spec[r_wr_ptr] <= w_spec;
            r_ill[r_wr_ptr]  <= w_ill;
            r_pc[r_wr_ptr]   <= in_pc;
        end
    end

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign count     = r_count;

    // Data outputs are zeroed while empty so stale entries never leak downstream
    assign out_instruction_data = out_valid ? r_data[r_rd_ptr] : '0;
    assign out_opcode           = out_valid ? r_op[r_rd_ptr]   : '0;
    assign out_group            = out_valid ? r_grp[r_rd_ptr]  : '0;
    assign out_specifier        = out_valid ? r_spec[r_rd_ptr] : 1'b0;
    assign out_illegal          = out_valid ? r_ill[r_rd_ptr]  : 1'b0;
    assign out_pc               = out_valid ? r_pc[r_rd_ptr]   : '0;

endmodule

// File: tb/tb_instruction_predecode_buffer.sv
// Directed bench for instruction_predecode_buffer (DEPTH=2): inputs change and outputs
// are sampled on the falling edge, expectations are hand-derived constants.
module tb_instruction_predecode_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] out_instruction_data;
    logic [6:0]  out_opcode;
    logic [1:0]  out_group;
    logic        out_specifier;
    logic        out_illegal;
    logic [31:0] out_pc;
    logic [1:0]  count;

    int total = 0;
    int bad   = 0;

    instruction_predecode_buffer #(.DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction_data(out_instruction_data), .out_opcode(out_opcode),
        .out_group(out_group), .out_specifier(out_specifier), .out_illegal(out_illegal),
        .out_pc(out_pc), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                            input logic [1:0] grp, input logic spec, input logic ill);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".data"},  32'(out_instruction_data), instr >> 7);
        chk({tag, ".op"},    32'(out_opcode), 32'(instr[6:0]));
        chk({tag, ".grp"},   32'(out_group), 32'(grp));
        chk({tag, ".spec"},  32'(out_specifier), 32'(spec));
        chk({tag, ".ill"},   32'(out_illegal), 32'(ill));
        chk({tag, ".pc"},    out_pc, pc);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".cnt"},   32'(count), 32'd0);
        chk({tag, ".rdy"},   32'(in_ready), 32'd1);
        chk({tag, ".data"},  32'(out_instruction_data), 32'd0);
        chk({tag, ".grp"},   32'(out_group), 32'd0);
        chk({tag, ".pc"},    out_pc, 32'd0);
    endtask

    // Stream table: opcode, expected group, expected specifier
    logic [6:0] s_op   [8] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17};
    logic [1:0] s_grp  [8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    logic       s_spec [8] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};

    function automatic logic [31:0] s_instr(input int k);
        logic [6:0] op;
        op = s_op[k];
        return 32'hABC00000 | (32'(k) << 7) | 32'(op);
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        #12;
        chk_empty("reset");
        @(negedge clk); rst_n = 1'b1;

        // single R-type push
        in_valid = 1'b1; in_instr = 32'h00C58533; in_pc = 32'h100;
        @(negedge clk);
        chk_head("add", 32'h00C58533, 32'h100, 2'b01, 1'b0, 1'b0);
        chk("add.cnt", 32'(count), 32'd1);
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk_empty("flush1");

        // fill, back-pressure, then drain
        in_valid = 1'b1; in_instr = 32'h00112023; in_pc = 32'h200;
        @(negedge clk);
        in_instr = 32'h00B50463; in_pc = 32'h204;
        @(negedge clk);
        in_instr = 32'h0000006F; in_pc = 32'h208;
        chk("full.cnt", 32'(count), 32'd2);
        chk("full.rdy", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("hold.cnt", 32'(count), 32'd2);
        chk_head("sw", 32'h00112023, 32'h200, 2'b10, 1'b0, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("pop1.cnt", 32'(count), 32'd1);
        chk_head("beq", 32'h00B50463, 32'h204, 2'b10, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pop2.cnt", 32'(count), 32'd1);
        chk_head("jal", 32'h0000006F, 32'h208, 2'b11, 1'b1, 1'b0);
        @(negedge clk);
        chk_empty("drain");

        // streaming with both sides ready
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_instr = s_instr(k); in_pc = 32'h300 + 32'(4 * k);
            @(negedge clk);
            chk($sformatf("strm%0d.cnt", k), 32'(count), 32'd1);
            chk_head($sformatf("strm%0d", k), s_instr(k), 32'h300 + 32'(4 * k),
                     s_grp[k], s_spec[k], 1'b0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk_empty("strm.end");

        // illegal opcode is still buffered
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h400;
        @(negedge clk);
        in_valid = 1'b0;
        chk_head("ill", 32'hFFFFFFFF, 32'h400, 2'b00, 1'b0, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        chk_empty("ill.pop");

        // flush while full overrides a coincident push and pop
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00000033; in_pc = 32'h500;
        @(negedge clk);
        in_pc = 32'h504;
        @(negedge clk);
        chk("fl.cnt", 32'(count), 32'd2);
        flush = 1'b1; out_ready = 1'b1; in_instr = 32'h00000013; in_pc = 32'h508;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk_empty("fl");
        @(negedge clk);
        chk_empty("fl.after");

        // asynchronous reset between edges
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00000037; in_pc = 32'h600;
        @(negedge clk);
        in_pc = 32'h604;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ar.cnt", 32'(count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk_empty("arst");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk_empty("arst.rel");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
